// File: rtl/in_hand_shaking_fifo_if.sv
// Handshake bundle between the upstream link, the input FIFO and the downstream
// output-handshake stage.
interface in_hand_shaking_fifo_if #(
    parameter int unsigned DEPTH = 4
);
    logic                     si;
    logic [63:0]              in_packet;
    logic                     ri;
    logic                     read_en;
    logic                     empty;
    logic                     full;
    logic [63:0]              out_packet;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output si, in_packet, read_en,
        input  ri, empty, full, out_packet, count
    );

    modport slave (
        input  si, in_packet, read_en,
        output ri, empty, full, out_packet, count
    );
endinterface

// File: rtl/in_hand_shaking_fifo.sv
// Input-side router stage: si/ri valid-ready ingress into a small circular FIFO
// with a show-ahead head for the downstream output-handshake stage.
module in_hand_shaking_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input logic                    clk,
    input logic                    reset,
    in_hand_shaking_fifo_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FullCount = (PTR_W + 1)'(DEPTH);

    logic [63:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;

    // Flags depend only on registered count, so no comb path from si or read_en.
    assign empty = (count == '0);
    assign full  = (count == FullCount);
    assign push  = bus.si && !full;
    assign pop   = bus.read_en && !empty;

    assign bus.ri         = !full;
    assign bus.empty      = empty;
    assign bus.full       = full;
    assign bus.count      = count;
    assign bus.out_packet = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= bus.in_packet;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_in_hand_shaking_fifo.sv
// Directed self-checking bench for in_hand_shaking_fifo with a queue-based
// downstream consumer for the streaming phase.
module tb_in_hand_shaking_fifo;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    in_hand_shaking_fifo_if #(.DEPTH(4)) bus ();

    in_hand_shaking_fifo #(.DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [63:0] pkts [20];
    int tx, rx, model_cnt;
    logic ro, do_push, do_pop;

    initial begin
        reset       = 1'b1;
        bus.si        = 1'b0;
        bus.in_packet = '0;
        bus.read_en   = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("rst_count", 64'(bus.count), 64'd0);
        check("rst_empty", 64'(bus.empty), 64'd1);
        check("rst_full", 64'(bus.full), 64'd0);
        check("rst_ri", 64'(bus.ri), 64'd1);
        check("rst_out", bus.out_packet, 64'h0);
        tick();
        reset = 1'b1;

        // Fill to full, then hold an extra packet that must be refused.
        bus.si = 1'b1;
        bus.in_packet = 64'h1;
        tick();
        check("push1_empty", 64'(bus.empty), 64'd0);
        check("push1_head", bus.out_packet, 64'h1);
        for (int v = 2; v <= 4; v++) begin
            bus.in_packet = 64'(v);
            tick();
        end
        check("fill_full", 64'(bus.full), 64'd1);
        check("fill_ri", 64'(bus.ri), 64'd0);
        check("fill_count", 64'(bus.count), 64'd4);
        bus.in_packet = 64'h5;
        tick();
        check("ovf_count", 64'(bus.count), 64'd4);
        check("ovf_head", bus.out_packet, 64'h1);

        // Push and pop while full: only the pop happens.
        bus.read_en = 1'b1;
        check("pp_full_ri", 64'(bus.ri), 64'd0);
        tick();
        check("pp_full_count", 64'(bus.count), 64'd3);
        check("pp_full_head", bus.out_packet, 64'h2);
        check("pp_full_ri_after", 64'(bus.ri), 64'd1);
        bus.si = 1'b0;
        for (int v = 2; v <= 4; v++) begin
            check($sformatf("drain_%0d", v), bus.out_packet, 64'(v));
            tick();
        end
        bus.read_en = 1'b0;
        check("drain_empty", 64'(bus.empty), 64'd1);
        check("drain_count", 64'(bus.count), 64'd0);

        // Wrap-around at occupancy 1..2.
        bus.si = 1'b1;
        bus.in_packet = 64'h10;
        tick();
        bus.in_packet = 64'h11;
        tick();
        check("wrap_count2", 64'(bus.count), 64'd2);
        bus.read_en = 1'b1;
        for (int v = 'h12; v <= 'h19; v++) begin
            bus.in_packet = 64'(v);
            check($sformatf("wrap_out_%0h", v - 2), bus.out_packet, 64'(v - 2));
            tick();
            check("wrap_pp_count", 64'(bus.count), 64'd2);
        end
        bus.si = 1'b0;
        for (int v = 'h18; v <= 'h19; v++) begin
            check($sformatf("wrap_out_%0h", v), bus.out_packet, 64'(v));
            tick();
        end
        bus.read_en = 1'b0;
        check("wrap_empty", 64'(bus.empty), 64'd1);

        // Push and pop while empty: the pop is ignored.
        bus.si = 1'b1;
        bus.read_en = 1'b1;
        bus.in_packet = 64'h77;
        tick();
        check("pp_empty_count", 64'(bus.count), 64'd1);
        check("pp_empty_head", bus.out_packet, 64'h77);
        bus.si = 1'b0;
        tick();
        check("pp_empty_drain", 64'(bus.count), 64'd0);

        // Reads on empty must not move anything.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("empty_rd_count", 64'(bus.count), 64'd0);
        end
        bus.read_en = 1'b0;
        bus.si = 1'b1;
        bus.in_packet = 64'hBB;
        tick();
        check("empty_rd_head", bus.out_packet, 64'hBB);
        bus.si = 1'b0;
        bus.read_en = 1'b1;
        tick();
        bus.read_en = 1'b0;

        // Asynchronous reset mid-stream with three entries held.
        bus.si = 1'b1;
        for (int v = 'h31; v <= 'h33; v++) begin
            bus.in_packet = 64'(v);
            tick();
        end
        bus.si = 1'b0;
        check("pre_rst_count", 64'(bus.count), 64'd3);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_count", 64'(bus.count), 64'd0);
        check("mid_rst_empty", 64'(bus.empty), 64'd1);
        check("mid_rst_ri", 64'(bus.ri), 64'd1);
        check("mid_rst_out", bus.out_packet, 64'h0);
        reset = 1'b1;
        bus.si = 1'b1;
        bus.in_packet = 64'hA5;
        tick();
        check("post_rst_head", bus.out_packet, 64'hA5);
        check("post_rst_count", 64'(bus.count), 64'd1);
        bus.si = 1'b0;
        bus.read_en = 1'b1;
        tick();
        bus.read_en = 1'b0;

        // Random streaming against a downstream consumer with ro stalls.
        for (int i = 0; i < 20; i++) begin
            pkts[i] = {$urandom, $urandom};
        end
        tx = 0;
        rx = 0;
        model_cnt = 0;
        for (int cyc = 0; cyc < 2000 && rx < 20; cyc++) begin
            bus.si        = (tx < 20) && ($urandom_range(0, 1) == 1);
            bus.in_packet = (tx < 20) ? pkts[tx] : 64'h0;
            ro            = ($urandom_range(0, 2) != 0);
            bus.read_en   = ro && (model_cnt != 0);
            check("stream_ri", 64'(bus.ri), 64'(model_cnt != 4));
            do_push = bus.si && (model_cnt != 4);
            do_pop  = bus.read_en;
            if (do_pop) begin
                check($sformatf("stream_rx_%0d", rx), bus.out_packet, pkts[rx]);
                rx++;
            end
            if (do_push) tx++;
            model_cnt = model_cnt + int'(do_push) - int'(do_pop);
            tick();
        end
        bus.si = 1'b0;
        bus.read_en = 1'b0;
        check("stream_received", 64'(rx), 64'd20);
        check("stream_final_empty", 64'(bus.empty), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
